// File: rtl/fp32_pkg.sv
// FP32 field layout, special-value constants and FSM states shared by the
// accumulator, its classifier and the adder.
package fp32_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  localparam logic [31:0]      FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0]      FP32_PINF = 32'h7F800000;
  localparam logic [31:0]      FP32_NINF = 32'hFF800000;
  localparam logic [EXP_W-1:0] EXP_ALL1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[SIGN_BIT-1 -: EXP_W] == EXP_ALL1) && (v[MANT_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[SIGN_BIT-1 -: EXP_W] == EXP_ALL1) && (v[MANT_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/FP32_CLA_Adder.sv
// Combinational FP32 adder, round-to-nearest-even, denormal aware.
// Overflow saturates to signed Inf; NaN/Inf operands are screened upstream.
module FP32_CLA_Adder
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] w_big, w_small;
  logic [8:0]  w_exp_big, w_exp_small, w_diff;
  logic [27:0] w_ext_big, w_ext_small, w_aligned, w_raw, w_norm;
  logic        w_sub, w_round_up;
  logic [9:0]  w_exp_n, w_exp_r;
  logic [24:0] w_rounded;

  // Order by magnitude so the aligned subtraction never goes negative.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      w_big   = a;
      w_small = b;
    end else begin
      w_big   = b;
      w_small = a;
    end
    w_exp_big   = (w_big[30:23] == '0)   ? 9'd1 : {1'b0, w_big[30:23]};
    w_exp_small = (w_small[30:23] == '0) ? 9'd1 : {1'b0, w_small[30:23]};
    w_diff      = w_exp_big - w_exp_small;
    w_ext_big   = {1'b0, |w_big[30:23],   w_big[22:0],   3'b000};
    w_ext_small = {1'b0, |w_small[30:23], w_small[22:0], 3'b000};
    w_sub       = w_big[SIGN_BIT] ^ w_small[SIGN_BIT];
  end

  always_comb begin
    if (w_diff > 9'd26) begin
      w_aligned = {27'd0, |w_ext_small};
    end else begin
      w_aligned    = w_ext_small >> w_diff;
      w_aligned[0] = w_aligned[0] | (|(w_ext_small & ((28'd1 << w_diff) - 28'd1)));
    end
    w_raw = w_sub ? (w_ext_big - w_aligned) : (w_ext_big + w_aligned);
  end

  always_comb begin
    w_norm  = w_raw;
    w_exp_n = {1'b0, w_exp_big};
    if (w_raw[27]) begin
      w_norm  = {1'b0, w_raw[27:2], w_raw[1] | w_raw[0]};
      w_exp_n = w_exp_n + 10'd1;
    end else begin
      // Stop at exponent 1 so tiny results fall out as denormals.
      for (int i = 0; i < 26; i++) begin
        if (!w_norm[26] && (w_exp_n > 10'd1)) begin
          w_norm  = w_norm << 1;
          w_exp_n = w_exp_n - 10'd1;
        end
      end
    end
    w_round_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_rounded  = {1'b0, w_norm[26:3]} + 25'(w_round_up);
    w_exp_r    = w_exp_n;
    if (w_rounded[24]) begin
      w_exp_r   = w_exp_n + 10'd1;
      w_rounded = w_rounded >> 1;
    end
    if (w_exp_r >= 10'd255) begin
      sum = {w_big[SIGN_BIT], EXP_ALL1, 23'd0};
    end else if (w_rounded == '0) begin
      sum = {w_big[SIGN_BIT] & ~w_sub, 31'd0};
    end else begin
      sum = {w_big[SIGN_BIT], (w_rounded[23] ? w_exp_r[7:0] : 8'd0), w_rounded[22:0]};
    end
  end

endmodule

// File: rtl/fp32_special_detect.sv
// Combinational classifier: flags one FP32 operand as NaN, +Inf or -Inf.
module fp32_special_detect
  import fp32_pkg::*;
(
  input  logic [31:0] i_data,
  output logic        o_nan,
  output logic        o_pinf,
  output logic        o_ninf
);

  logic w_inf;

  assign w_inf  = is_inf(i_data);
  assign o_nan  = is_nan(i_data);
  assign o_pinf = w_inf && !i_data[SIGN_BIT];
  assign o_ninf = w_inf &&  i_data[SIGN_BIT];

endmodule

// File: rtl/fp32_accumulator.sv
// Streaming FP32 packet sum: folds operands into a running sum and presents
// one registered result (sum, count, NaN/Inf status) per packet.
module fp32_accumulator
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_inf
);

  state_t             r_state, w_state_next;
  logic [31:0]        r_acc, w_acc_next, w_sum;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic               r_nan_seen, r_pinf_seen, r_ninf_seen;
  logic               w_nan_next, w_pinf_next, w_ninf_next;
  logic               w_nan, w_pinf, w_ninf, w_special;
  logic               w_accept, w_first;
  logic [31:0]        r_out_data, w_res_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_nan, r_out_inf, w_res_nan, w_res_inf;

  FP32_CLA_Adder u_adder (
    .a   (r_acc),
    .b   (in_data),
    .sum (w_sum)
  );

  fp32_special_detect u_detect (
    .i_data (in_data),
    .o_nan  (w_nan),
    .o_pinf (w_pinf),
    .o_ninf (w_ninf)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_state == IDLE);
  assign w_special = w_nan || w_pinf || w_ninf;

  // First operand loads directly so signed zero and exact values survive.
  always_comb begin
    w_acc_next = r_acc;
    if (!w_special) begin
      w_acc_next = w_first ? in_data : w_sum;
    end
    w_nan_next  = w_nan  || (!w_first && r_nan_seen);
    w_pinf_next = w_pinf || (!w_first && r_pinf_seen);
    w_ninf_next = w_ninf || (!w_first && r_ninf_seen);
    if (w_first) begin
      w_count_next = CNT_W'(1);
    end else if (r_count == '1) begin
      w_count_next = r_count;
    end else begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_res_data = w_acc_next;
    w_res_nan  = 1'b0;
    w_res_inf  = (w_acc_next[30:23] == EXP_ALL1);
    if (w_nan_next || (w_pinf_next && w_ninf_next)) begin
      w_res_data = FP32_QNAN;
      w_res_nan  = 1'b1;
      w_res_inf  = 1'b0;
    end else if (w_pinf_next) begin
      w_res_data = FP32_PINF;
      w_res_inf  = 1'b1;
    end else if (w_ninf_next) begin
      w_res_data = FP32_NINF;
      w_res_inf  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_nan_seen  <= 1'b0;
      r_pinf_seen <= 1'b0;
      r_ninf_seen <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_nan   <= 1'b0;
      r_out_inf   <= 1'b0;
    end else if (w_accept) begin
      r_acc       <= w_acc_next;
      r_count     <= w_count_next;
      r_nan_seen  <= w_nan_next;
      r_pinf_seen <= w_pinf_next;
      r_ninf_seen <= w_ninf_next;
      if (in_last) begin
        r_out_data  <= w_res_data;
        r_out_count <= w_count_next;
        r_out_nan   <= w_res_nan;
        r_out_inf   <= w_res_inf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = in_last ? HOLD : ACCUM;
      ACCUM:   if (w_accept && in_last) w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != HOLD);
    out_valid = (r_state == HOLD);
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_nan   = r_out_nan;
  assign out_inf   = r_out_inf;

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed bench for fp32_accumulator: hand-computed packet sums, special
// values, backpressure, overflow and asynchronous reset mid-packet.
module tb_fp32_accumulator;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [31:0]      in_data;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_nan, out_inf;

  int checks   = 0;
  int failures = 0;

  fp32_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_nan   (out_nan),
    .out_inf   (out_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [31:0] d, input logic last);
    chk("in_ready_before_push", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!last) chk("out_valid_mid_packet", 32'(out_valid), 32'd0);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] d, input int cnt,
                               input logic nan, input logic inf);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".out_data"},  out_data,       d);
    chk({tag, ".out_count"}, 32'(out_count), 32'(cnt));
    chk({tag, ".out_nan"},   32'(out_nan),   32'(nan));
    chk({tag, ".out_inf"},   32'(out_inf),   32'(inf));
    $display("pkt %s data=%h count=%0d nan=%0b inf=%0b", tag, out_data, out_count, out_nan, out_inf);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  out_data,       32'd0);
    chk("rst.out_count", 32'(out_count), 32'd0);
    chk("rst.out_nan",   32'(out_nan),   32'd0);
    chk("rst.out_inf",   32'(out_inf),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.5 + 2.5 = 4.0
    push(32'h3FC00000, 1'b0);
    push(32'h40200000, 1'b1);
    expect_result("basic", 32'h40800000, 2, 1'b0, 1'b0);

    // Single element -1.0
    push(32'hBF800000, 1'b1);
    expect_result("single", 32'hBF800000, 1, 1'b0, 1'b0);

    // 1.0 + 1.0 + 2.0 with a stray in_last while idle-valid and backpressure
    push(32'h3F800000, 1'b0);
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready",  32'(in_ready),  32'd0);
      chk("hold.out_data",  out_data,       32'h40800000);
      chk("hold.out_count", 32'(out_count), 32'd3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("chain", 32'h40800000, 3, 1'b0, 1'b0);

    // 3.25 + -1.5 = 1.75
    push(32'h40500000, 1'b0);
    push(32'hBFC00000, 1'b1);
    expect_result("subtract", 32'h3FE00000, 2, 1'b0, 1'b0);

    // NaN in the middle of a packet
    push(32'h3F800000, 1'b0);
    push(32'h7FC00000, 1'b0);
    push(32'h40000000, 1'b1);
    expect_result("nan", 32'h7FC00000, 3, 1'b1, 1'b0);

    // +Inf and -Inf cancel to NaN
    push(32'h7F800000, 1'b0);
    push(32'hFF800000, 1'b1);
    expect_result("inf_cancel", 32'h7FC00000, 2, 1'b1, 1'b0);

    // +Inf dominates a finite operand
    push(32'h7F800000, 1'b0);
    push(32'h3F800000, 1'b1);
    expect_result("pinf", 32'h7F800000, 2, 1'b0, 1'b1);

    // Adder overflow: max finite + max finite -> +Inf
    push(32'h7F7FFFFF, 1'b0);
    push(32'h7F7FFFFF, 1'b1);
    expect_result("overflow", 32'h7F800000, 2, 1'b0, 1'b1);

    // Asynchronous reset discards a partial packet
    push(32'h3FC00000, 1'b0);
    push(32'h40200000, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready",  32'(in_ready),  32'd1);
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    push(32'h40500000, 1'b1);
    expect_result("after_rst", 32'h40500000, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
